// File: rtl/div_sequencer_pkg.sv
`default_nettype none
// =============================================================================
// div_sequencer_pkg : state encoding and constants shared by the divide unit
// Revision: 1.0
// =============================================================================
package div_sequencer_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITER  = DIV_WIDTH;

    // Quotient reported for a zero divisor.
    localparam logic [DIV_WIDTH-1:0] DZ_QUOTIENT = '1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_CALC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } div_state_t;

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// =============================================================================
// div_step : one combinational restoring-divide iteration on {rem,quo}
// Revision: 1.0
// =============================================================================
module div_step
    import div_sequencer_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor_mag,
    output logic [WIDTH:0]   rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_trial;

    // One extra headroom bit so the trial sign is always the top bit.
    assign w_shift  = {rem, quo[WIDTH-1]};
    assign w_trial  = w_shift - {2'b00, divisor_mag};
    assign rem_next = w_trial[WIDTH+1] ? w_shift[WIDTH:0] : w_trial[WIDTH:0];
    assign quo_next = {quo[WIDTH-2:0], ~w_trial[WIDTH+1]};

endmodule
`default_nettype wire

// File: rtl/div_sequencer.sv
`default_nettype none
// =============================================================================
// div_sequencer : multi-cycle DIV/DIVU engine that stalls the front end and
//                 delivers quotient to LO and remainder to HI with one pulse
// Revision: 1.0
// =============================================================================
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             cancel,
    output logic             stall,
    output logic             done,
    output logic             to_hi,
    output logic             to_lo,
    output logic [WIDTH-1:0] hi_data,
    output logic [WIDTH-1:0] lo_data,
    output logic             div_by_zero
);

    localparam int                 c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    div_state_t         r_state;
    div_state_t         w_state_nxt;
    logic [WIDTH-1:0]   r_dividend;
    logic [WIDTH-1:0]   r_divisor;
    logic               r_signed;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [WIDTH:0]     r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dvsr_mag;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_dbz;
    logic               w_accept;
    logic               w_dvsr_zero;
    logic [WIDTH-1:0]   w_dividend_mag;
    logic [WIDTH-1:0]   w_divisor_mag;
    logic [WIDTH:0]     w_rem_nxt;
    logic [WIDTH-1:0]   w_quo_nxt;

    assign w_accept       = (r_state == ST_IDLE) && start && !cancel;
    assign w_dvsr_zero    = (r_divisor == '0);
    assign w_dividend_mag = (r_signed && r_dividend[WIDTH-1]) ? -r_dividend : r_dividend;
    assign w_divisor_mag  = (r_signed && r_divisor[WIDTH-1])  ? -r_divisor  : r_divisor;

    div_step #(
        .WIDTH       (WIDTH)
    ) u_step (
        .rem         (r_rem),
        .quo         (r_quo),
        .divisor_mag (r_dvsr_mag),
        .rem_next    (w_rem_nxt),
        .quo_next    (w_quo_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_PREP;
            ST_PREP: w_state_nxt = w_dvsr_zero ? ST_DONE : ST_CALC;
            ST_CALC: if (r_cnt == '0) w_state_nxt = ST_FIX;
            ST_FIX:  w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (cancel && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // Every datapath update is suppressed by cancel so results stay intact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dividend <= '0;
            r_divisor  <= '0;
            r_signed   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_dvsr_mag <= '0;
            r_cnt      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_dbz      <= 1'b0;
        end else if (!cancel) begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_dividend <= dividend;
                        r_divisor  <= divisor;
                        r_signed   <= signed_op;
                        r_dbz      <= 1'b0;
                    end
                end
                ST_PREP: begin
                    r_neg_q    <= r_signed & (r_dividend[WIDTH-1] ^ r_divisor[WIDTH-1]);
                    r_neg_r    <= r_signed & r_dividend[WIDTH-1];
                    r_quo      <= w_dividend_mag;
                    r_dvsr_mag <= w_divisor_mag;
                    r_rem      <= '0;
                    r_cnt      <= c_last;
                    if (w_dvsr_zero) begin
                        r_lo  <= WIDTH'(DZ_QUOTIENT);
                        r_hi  <= r_dividend;
                        r_dbz <= 1'b1;
                    end
                end
                ST_CALC: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_FIX: begin
                    r_lo <= r_neg_q ? -r_quo : r_quo;
                    r_hi <= r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

    // Gated by reset so the front end is released the instant reset asserts.
    assign stall = rst_n && (w_accept || (r_state == ST_PREP) ||
                             (r_state == ST_CALC) || (r_state == ST_FIX));
    assign done        = (r_state == ST_DONE);
    assign to_hi       = done;
    assign to_lo       = done;
    assign hi_data     = r_hi;
    assign lo_data     = r_lo;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_div_sequencer.sv
`default_nettype none
// =============================================================================
// tb_div_sequencer : directed DIV/DIVU vectors checked against an arithmetic
//                    reference model every cycle plus literal expectations
// Revision: 1.0
// =============================================================================
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        signed_op = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        cancel = 1'b0;
    logic        stall, done, to_hi, to_lo, div_by_zero;
    logic [31:0] hi_data, lo_data;

    int n_vec  = 0;
    int n_miss = 0;

    div_sequencer #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_op   (signed_op),
        .dividend    (dividend),
        .divisor     (divisor),
        .cancel      (cancel),
        .stall       (stall),
        .done        (done),
        .to_hi       (to_hi),
        .to_lo       (to_lo),
        .hi_data     (hi_data),
        .lo_data     (lo_data),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: truncating division on magnitudes, signs restored afterwards.
    function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output logic dz);
        logic [31:0] ma, mb, qm, rm;
        if (b == 32'd0) begin
            q  = 32'hFFFF_FFFF;
            r  = a;
            dz = 1'b1;
        end else begin
            ma = (s && a[31]) ? 32'd0 - a : a;
            mb = (s && b[31]) ? 32'd0 - b : b;
            qm = ma / mb;
            rm = ma % mb;
            q  = (s && (a[31] != b[31])) ? 32'd0 - qm : qm;
            r  = (s && a[31]) ? 32'd0 - rm : rm;
            dz = 1'b0;
        end
    endfunction

    // Model: cycles remaining until the done cycle, plus pending results.
    int          m_left = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic        m_dbz = 1'b0, p_dbz = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0; m_done = 1'b0;
            m_hi = '0; m_lo = '0; m_dbz = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_left > 0) begin
            if (cancel) begin
                m_left = 0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    m_hi = p_hi; m_lo = p_lo; m_dbz = p_dbz;
                end
            end
        end else if (start && !cancel) begin
            ref_div(signed_op, dividend, divisor, p_lo, p_hi, p_dbz);
            m_dbz  = 1'b0;
            m_left = (divisor == 32'd0) ? 1 : 34;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("stall", {31'd0, stall},
                {31'd0, (m_left > 0) || (!m_done && start && !cancel)});
            chk("done",  {31'd0, done},  {31'd0, m_done});
            chk("to_hi", {31'd0, to_hi}, {31'd0, m_done});
            chk("to_lo", {31'd0, to_lo}, {31'd0, m_done});
            chk("hi_data", hi_data, m_hi);
            chk("lo_data", lo_data, m_lo);
            chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, m_dbz});
        end
    end

    time last_done_t = 0;

    task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        signed_op = s; dividend = a; divisor = b; start = 1'b1;
    endtask

    task automatic finish_div(input string name, input int exp_lat, input logic [31:0] exp_lo,
                              input logic [31:0] exp_hi, input logic exp_dz);
        int lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) break;
            lat++;
        end
        last_done_t = $time;
        chk($sformatf("%s latency", name), lat, exp_lat);
        chk($sformatf("%s lo", name), lo_data, exp_lo);
        chk($sformatf("%s hi", name), hi_data, exp_hi);
        chk($sformatf("%s dbz", name), {31'd0, div_by_zero}, {31'd0, exp_dz});
        chk($sformatf("%s stall in done", name), {31'd0, stall}, 32'd0);
        #1 start = 1'b0;
    endtask

    initial begin
        logic [31:0] save_hi, save_lo;
        time t0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset stall", {31'd0, stall}, 32'd0);
        chk("reset done",  {31'd0, done},  32'd0);
        chk("reset hi",    hi_data, 32'd0);
        chk("reset lo",    lo_data, 32'd0);
        chk("reset dbz",   {31'd0, div_by_zero}, 32'd0);
        rst_n = 1'b1;

        launch(1'b0, 32'd100, 32'd7);
        finish_div("divu 100/7", 35, 32'd14, 32'd2, 1'b0);
        t0 = last_done_t;
        launch(1'b1, 32'hFFFF_FFF9, 32'd2);
        finish_div("div -7/2", 35, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        chk("back-to-back spacing", 32'((last_done_t - t0) / 10), 32'd36);
        launch(1'b0, 32'hFFFF_FFF9, 32'd2);
        finish_div("divu fff9/2", 35, 32'h7FFF_FFFC, 32'd1, 1'b0);
        launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        finish_div("div min/-1", 35, 32'h8000_0000, 32'd0, 1'b0);
        launch(1'b1, 32'd7, 32'hFFFF_FFFE);
        finish_div("div 7/-2", 35, 32'hFFFF_FFFD, 32'd1, 1'b0);
        launch(1'b0, 32'd5, 32'd0);
        finish_div("divu 5/0", 2, 32'hFFFF_FFFF, 32'd5, 1'b1);
        launch(1'b0, 32'd9, 32'd3);
        finish_div("divu 9/3", 35, 32'd3, 32'd0, 1'b0);
        launch(1'b1, 32'hFFFF_FFFB, 32'd0);
        finish_div("div -5/0", 2, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);

        save_hi = hi_data;
        save_lo = lo_data;
        launch(1'b0, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #1 cancel = 1'b1; start = 1'b0;
        @(posedge clk);
        #1 cancel = 1'b0;
        chk("cancel stall", {31'd0, stall}, 32'd0);
        chk("cancel done",  {31'd0, done},  32'd0);
        chk("cancel hi kept", hi_data, save_hi);
        chk("cancel lo kept", lo_data, save_lo);
        chk("cancel dbz", {31'd0, div_by_zero}, 32'd0);
        launch(1'b0, 32'd1000, 32'd3);
        finish_div("after cancel 1000/3", 35, 32'd333, 32'd1, 1'b0);

        launch(1'b1, 32'hFFFF_FF9C, 32'd7);
        repeat (20) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async rst stall", {31'd0, stall}, 32'd0);
        chk("async rst done",  {31'd0, done},  32'd0);
        chk("async rst hi", hi_data, 32'd0);
        chk("async rst lo", lo_data, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        finish_div("div -100/7 after reset", 35, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle divide sequencer that executes DIV/DIVU issued from the EX stage and owns the HI/LO write for them. It runs a 32-iteration restoring divide. While busy it holds the front of the pipeline (pc, if_id, id_ex) through a stall output. On completion it delivers the quotient to LO and the remainder to HI with a single-cycle write pulse into the hilo register block.

## Interface
- WIDTH, 32, operand/result width; iteration count equals WIDTH
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  EX holds a DIV/DIVU; level signal, sampled only in IDLE
- signed_op  in  1  1 = DIV (two's complement), 0 = DIVU
- dividend  in  WIDTH  EX rdata1, sampled with start
- divisor  in  WIDTH  EX rdata2, sampled with start
- cancel  in  1  flush; aborts any operation in flight
- stall  out  1  freeze pc/if_id/id_ex this cycle
- done  out  1  one-cycle completion pulse
- to_hi, to_lo  out  1 each  hilo write enables; equal to done
- hi_data  out  WIDTH  remainder (registered)
- lo_data  out  WIDTH  quotient (registered)
- div_by_zero  out  1  registered; set with done when divisor was 0, cleared at next accepted start

## Operation
- **Reset:** state IDLE. stall, done, to_hi, to_lo and div_by_zero are 0. hi_data and lo_data are 0. Counter is 0.
- **IDLE:** if start=1 and cancel=0, latch the operands and signed_op, then go to PREP.
- **PREP:**
  - Convert to magnitudes when signed_op=1. Record neg_q = sign(dividend) XOR sign(divisor) and neg_r = sign(dividend).
  - Clear the remainder accumulator (WIDTH+1 bits) and load the counter with WIDTH-1.
  - If divisor==0, go to DONE with lo=all-ones, hi=dividend (raw, unconverted) and div_by_zero=1.
  - Otherwise go to CALC.
- **CALC:** one restoring step per cycle.
  - Shift {rem,quo} left by 1 and compute trial = rem - divisor_mag.
  - If trial ≥ 0, rem=trial and the shifted-in quotient bit is 1; otherwise 0.
  - When counter==0, go to FIX; otherwise decrement the counter.
- **FIX:** negate the quotient if neg_q, negate the remainder if neg_r (signed only). Load hi_data/lo_data. Go to DONE.
- **DONE:** done=to_hi=to_lo=1 and stall=0 for this cycle. start is ignored. Go to IDLE.
- **stall:** equals (state∈{PREP,CALC,FIX}) OR (state==IDLE AND start AND NOT cancel). It is 0 in DONE, so the divide leaves EX on that edge.
- **cancel:**
  - In any state other than IDLE, go to IDLE next cycle.
  - No done pulse is produced, and hi_data, lo_data and div_by_zero keep their prior values.
  - cancel has priority over start in the same cycle.
- **Arithmetic rules:**
  - Signed 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0. This falls out of the magnitude path with no special case.
  - Magnitude of 0x80000000 is taken as an unsigned WIDTH-bit value.

## Timing
- Accepted start in cycle N leads to: PREP N+1, CALC N+2..N+33, FIX N+34, DONE N+35. done is high in cycle N+35 only.
- Divide by zero: start in N, PREP N+1, DONE N+2.
- hi_data and lo_data change only on the edge entering DONE. They are stable during the done cycle and until the next completion.
- stall is high in cycles N..N+34 (N..N+1 for divide by zero) and low in the DONE cycle.
- A new start is earliest in the cycle after DONE (back-to-back divides: the next done is 36 cycles after the previous one).
- cancel asserted in cycle M (state not IDLE): state is IDLE in M+1 and stall is 0 in M+1.
- Asynchronous reset mid-operation: all outputs return to their reset values immediately; no write pulse.

## Structure
- **Shared package:** the state encoding (IDLE, PREP, CALC, FIX, DONE), DIV_ITER = WIDTH, and the divide-by-zero result constants (quotient all-ones). The existing definitions header carries these.
- **Sub-module:** `div_step`, purely combinational. It takes rem/quo/divisor_mag and returns the next rem/quo, so the iteration can be unit-tested alone.
- **Top-level wiring:** to_hi/to_lo/hi_data/lo_data drive the hilo write port through a mux with the existing EX-stage MTHI/MTLO path. The sequencer path has priority when done=1.

## Test plan
- **DIVU 100/7:** start at N → done only at N+35; lo=14, hi=2; stall high N..N+34 and low at N+35.
- **DIV −7/2 (0xFFFFFFF9 / 2):** lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU with the same operands: lo=0x7FFFFFFC, hi=1.
- **DIV 0x80000000 / 0xFFFFFFFF:** lo=0x80000000, hi=0, div_by_zero=0.
- **Divide by zero, DIVU 5/0:** done at N+2; lo=0xFFFFFFFF, hi=5, div_by_zero=1. A following DIVU 9/3 clears the flag and gives lo=3, hi=0.
- **cancel at N+10:** no done pulse, stall=0 at N+11, hi/lo unchanged. A start at N+12 completes normally at N+47.
- **rst low at N+20 (asynchronous, mid-CALC):** stall=0 and hi/lo=0 immediately. After release, with start held, the operation restarts and completes at N'+35.
